// File: rtl/posit_pkg.sv
// Shared posit<16,2> constants, the decoded-field struct and the scale helper
// used by posit_decode and posit_add.
package posit_pkg;

  localparam int POSIT_N  = 16;
  localparam int POSIT_ES = 2;
  localparam int POSIT_BS = $clog2(POSIT_N);

  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;

  // mant carries the hidden one in its MSB; k is the signed regime value.
  typedef struct packed {
    logic                            sign;
    logic                            is_zero;
    logic                            is_nar;
    logic signed [POSIT_BS:0]        k;
    logic [POSIT_ES-1:0]             exp;
    logic [POSIT_N-POSIT_ES-1:0]     mant;
  } posit_fields_t;

  function automatic int scale_of(input posit_fields_t f);
    return (int'(f.k) * (2 ** POSIT_ES)) + int'(f.exp);
  endfunction

endpackage

// File: rtl/posit_decode.sv
// Splits one posit word into sign, regime, exponent and mantissa with the
// hidden one restored; negative words are two's-complemented first.
module posit_decode
  import posit_pkg::*;
(
  input  logic [POSIT_N-1:0] word,
  output posit_fields_t      fields
);

  localparam int KW = POSIT_BS + 1;
  localparam logic [POSIT_N-2:0] BODY_ONE = {{(POSIT_N-2){1'b0}}, 1'b1};

  logic [POSIT_N-2:0] body;
  logic [POSIT_N-2:0] rest;
  logic               run_bit;
  logic               stop;
  int                 run;

  always_comb begin
    body    = word[POSIT_N-1] ? (~word[POSIT_N-2:0] + BODY_ONE) : word[POSIT_N-2:0];
    run_bit = body[POSIT_N-2];
    run     = 0;
    stop    = 1'b0;
    for (int i = POSIT_N - 2; i >= 0; i--) begin
      if (!stop && (body[i] == run_bit)) run++;
      else stop = 1'b1;
    end
    // drop the regime run and its terminating bit; missing bits shift in as 0
    rest = body << (run + 1);

    fields.sign    = word[POSIT_N-1];
    fields.is_zero = (word == POSIT_ZERO);
    fields.is_nar  = (word == POSIT_NAR);
    fields.k       = run_bit ? KW'(run - 1) : KW'(-run);
    fields.exp     = rest[POSIT_N-2 -: POSIT_ES];
    fields.mant    = {1'b1, rest[POSIT_N-2-POSIT_ES:0]};
  end

endmodule

// File: rtl/posit_add.sv
// Single-cycle posit adder with registered sum and NaR/zero flags.
// Define POSIT_ADD_RNE_EN for round-to-nearest-even; otherwise the sum truncates.
module posit_add
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int es = POSIT_ES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         start,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero,
  output logic         done
);

  localparam int Bs   = $clog2(N);
  localparam int SW   = Bs + es + 2;
  localparam int MW   = N - es;
  localparam int AW   = MW + 3;
  localparam int SUMW = AW + 1;
  localparam int FW   = SUMW - 1;
  localparam int XW   = AW + N + 3;
  localparam int LW   = 2 + es + FW + N;
  localparam logic [N-2:0] MAG_ONE = {{(N-2){1'b0}}, 1'b1};
  localparam logic [N-2:0] MAG_MAX = '1;

  posit_fields_t fa, fb;

  posit_decode u_dec_a (.word(in1), .fields(fa));
  posit_decode u_dec_b (.word(in2), .fields(fb));

  logic signed [SW-1:0] scale_a, scale_b, scale_big, scale_small;
  logic                 a_big, sign_big, sign_small;
  logic [MW-1:0]        mant_big, mant_small;
  logic [XW-1:0]        shift_ext;
  logic [AW-1:0]        al_big, al_small;
  logic [SUMW-1:0]      sum;
  logic [FW-1:0]        frac_n;
  logic [es-1:0]        exp_n;
  logic [1:0]           seed_hi;
  logic signed [LW-1:0] enc_vec;
  logic [N-2:0]         mag_trunc, mag_rnd, mag;
  logic [N-1:0]         result;
  int                   diff, lead, scale_n, k_n, enc_sh;

  always_comb begin
    scale_a = SW'(scale_of(fa));
    scale_b = SW'(scale_of(fb));
    a_big   = (scale_a > scale_b) || ((scale_a == scale_b) && (fa.mant >= fb.mant));

    scale_big   = a_big ? scale_a : scale_b;
    scale_small = a_big ? scale_b : scale_a;
    mant_big    = a_big ? fa.mant : fb.mant;
    mant_small  = a_big ? fb.mant : fa.mant;
    sign_big    = a_big ? fa.sign : fb.sign;
    sign_small  = a_big ? fb.sign : fa.sign;

    // guard, round and sticky positions sit below the aligned mantissa
    diff      = int'(scale_big) - int'(scale_small);
    shift_ext = {mant_small, 3'b000, {(N+3){1'b0}}} >> diff;
    if (diff >= N + 3) al_small = AW'(1);
    else               al_small = shift_ext[XW-1 -: AW] | AW'(|shift_ext[XW-AW-1:0]);
    al_big = {mant_big, 3'b000};

    if (sign_big == sign_small) sum = {1'b0, al_big} + {1'b0, al_small};
    else                        sum = {1'b0, al_big} - {1'b0, al_small};

    lead = 0;
    for (int i = 0; i < SUMW; i++) begin
      if (sum[i]) lead = i;
    end
    frac_n  = FW'(sum << (SUMW - 1 - lead));
    scale_n = int'(scale_big) + lead - (AW - 1);
    k_n     = scale_n >>> es;
    exp_n   = es'(scale_n);

    // arithmetic shift of 10.. grows a ones run, of 01.. a zeros run
    seed_hi   = (k_n >= 0) ? 2'b10 : 2'b01;
    enc_sh    = (k_n >= 0) ? k_n : (-k_n - 1);
    enc_vec   = $signed({seed_hi, exp_n, frac_n, {N{1'b0}}}) >>> enc_sh;
    mag_trunc = enc_vec[LW-1 -: N-1];
  end

`ifdef POSIT_ADD_RNE_EN
  logic guard, sticky;

  always_comb begin
    guard  = enc_vec[LW-N];
    sticky = |enc_vec[LW-N-1:0];
    if (guard && (sticky || mag_trunc[0]) && (mag_trunc != MAG_MAX)) mag_rnd = mag_trunc + MAG_ONE;
    else                                                             mag_rnd = mag_trunc;
  end
`else
  logic unused_low;

  assign unused_low = |enc_vec[LW-N:0];
  assign mag_rnd    = mag_trunc;
`endif

  always_comb begin
    if (k_n > N - 2)         mag = MAG_MAX;
    else if (k_n < -(N - 2)) mag = MAG_ONE;
    else                     mag = mag_rnd;
    result = sign_big ? -{1'b0, mag} : {1'b0, mag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      inf  <= 1'b0;
      zero <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        if (fa.is_nar || fb.is_nar) begin
          out  <= POSIT_NAR;
          inf  <= 1'b1;
          zero <= 1'b0;
        end else if (fa.is_zero && fb.is_zero) begin
          out  <= POSIT_ZERO;
          inf  <= 1'b0;
          zero <= 1'b1;
        end else if (fa.is_zero) begin
          out  <= in2;
          inf  <= 1'b0;
          zero <= 1'b0;
        end else if (fb.is_zero) begin
          out  <= in1;
          inf  <= 1'b0;
          zero <= 1'b0;
        end else if (sum == '0) begin
          out  <= POSIT_ZERO;
          inf  <= 1'b0;
          zero <= 1'b1;
        end else begin
          out  <= result;
          inf  <= 1'b0;
          zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_add.sv
// Directed scoreboard bench for posit_add: expected results are queued at
// issue and popped when done pulses.
module tb_posit_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in1, in2;
  logic [15:0] out;
  logic        inf, zero, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] eo;
    logic        ei;
    logic        ez;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] eo;
    logic        ei;
    logic        ez;
  } vec_t;

  exp_t sb[$];

  vec_t vecs [16] = '{
    '{16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b0},
    '{16'h0000, 16'hB800, 16'hB800, 1'b0, 1'b0},
    '{16'h4000, 16'h4000, 16'h4800, 1'b0, 1'b0},
    '{16'h4000, 16'hC000, 16'h0000, 1'b0, 1'b1},
    '{16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0},
    '{16'h4000, 16'h8000, 16'h8000, 1'b1, 1'b0},
    '{16'h2000, 16'h2000, 16'h2800, 1'b0, 1'b0},
    '{16'h7000, 16'h7000, 16'h7200, 1'b0, 1'b0},
    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0},
    '{16'h7FFF, 16'h4000, 16'h7FFF, 1'b0, 1'b0},
    '{16'h4000, 16'h2000, 16'h4080, 1'b0, 1'b0},
    '{16'h4800, 16'hC000, 16'h4000, 1'b0, 1'b0},
    '{16'hC000, 16'hC000, 16'hB800, 1'b0, 1'b0},
    '{16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0},
    '{16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1},
    '{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0}
  };

  always #5 clk = ~clk;

  posit_add dut (
    .clk   (clk),
    .rst   (rst),
    .in1   (in1),
    .in2   (in2),
    .start (start),
    .out   (out),
    .inf   (inf),
    .zero  (zero),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] eo, input logic ei, input logic ez);
    exp_t e;
    e.eo = eo;
    e.ei = ei;
    e.ez = ez;
    in1   = a;
    in2   = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic collect(input string tag);
    int   n = 0;
    exp_t e;
    while (done !== 1'b1 && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done"}, {15'b0, done}, 16'h0001);
    if (sb.size() == 0) begin
      chk({tag, "_queue"}, 16'(sb.size()), 16'h0001);
    end else begin
      e = sb.pop_front();
      chk({tag, "_out"},  out,           e.eo);
      chk({tag, "_inf"},  {15'b0, inf},  {15'b0, e.ei});
      chk({tag, "_zero"}, {15'b0, zero}, {15'b0, e.ez});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in1   = 16'h0000;
    in2   = 16'h0000;
    #7;
    chk("rst_out",  out,           16'h0000);
    chk("rst_inf",  {15'b0, inf},  16'h0000);
    chk("rst_zero", {15'b0, zero}, 16'h0000);
    chk("rst_done", {15'b0, done}, 16'h0000);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    collect("zero_zero");
    @(posedge clk);
    #1;
    chk("done_pulse", {15'b0, done}, 16'h0000);

    // back-to-back issue: start stays high across consecutive edges
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].eo, vecs[i].ei, vecs[i].ez);
      collect($sformatf("vec%0d", i));
    end

    // NaR result is held, then reset mid-cycle must clear everything at once
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out",  out,           16'h0000);
    chk("arst_inf",  {15'b0, inf},  16'h0000);
    chk("arst_zero", {15'b0, zero}, 16'h0000);
    chk("arst_done", {15'b0, done}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(16'h4000, 16'h4000, 16'h4800, 1'b0, 1'b0);
    collect("post_rst");
    in1 = 16'h7FFF;
    in2 = 16'h7FFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_out%0d", i),  out,           16'h4800);
      chk($sformatf("hold_done%0d", i), {15'b0, done}, 16'h0000);
    end

    chk("sb_empty", 16'(sb.size()), 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
